alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Two-requester front end for the Argon ALU. It accepts complete operation requests (A, B, opcode, optional flags preload) from two clients and arbitrates between them round-robin. It drives the ALU's single bus through the latch/compute/output command sequence and returns Y, flags and an error bit on one shared response channel tagged with a requester id. It sits between the CPU control logic (or a debug port) and the ALU bus_if.

Parameters:
WORDSIZE, 16, data word width; must match the ALU.
FLAGW, 8, flags register width.

Ports:
i_Clk  in  1  clock
i_Reset  in  1  asynchronous, active-high reset
i_Req0Valid / i_Req1Valid  in  1  request N valid
o_Req0Ready / o_Req1Ready  out  1  request N accepted this cycle
i_Req0A / i_Req1A  in  WORDSIZE  operand A
i_Req0B / i_Req1B  in  WORDSIZE  operand B
i_Req0Op / i_Req1Op  in  4  ALU opcode
i_Req0LoadF / i_Req1LoadF  in  1  preload flags before compute
i_Req0Flags / i_Req1Flags  in  FLAGW  flags preload value
o_RespValid  out  1  response valid
i_RespReady  in  1  response consumed
o_RespId  out  1  requester that owns the response
o_RespY  out  WORDSIZE  result word
o_RespFlags  out  FLAGW  result flags
o_RespErr  out  1  bus protocol error during readback
o_BusCommand  out  com_t  command to the ALU bus
o_BusData  out  WORDSIZE  bus write data (ALU i_data)
o_BusValid  out  1  bus write valid (ALU i_valid)
i_BusData  in  WORDSIZE  bus read data (ALU o_data)
i_BusValid  in  1  bus read valid (ALU o_valid)

Behaviour:
- Clocking: one clock, i_Clk. Reset i_Reset is asynchronous, active-high.
- Reset values: state IDLE, all o_Resp* = 0, o_BusCommand = COM_NOP, o_BusData = 0, o_BusValid = 0, both Ready = 0, RR pointer = 1 (port 0 wins first tie).
- FSM states: IDLE, LATCH_A, LATCH_B, LATCH_OP, LATCH_F, COMPUTE, OUT_Y, OUT_F, RESP. Every state except IDLE and RESP lasts exactly one cycle.
- IDLE: o_ReqNReady is combinational.
  - Ready goes high only in IDLE, and only for the arbitration winner.
  - If one request is valid, it wins.
  - If both are valid, the port other than the last granted wins.
- Accept: on the edge where Valid & Ready, capture A, B, Op, LoadF, Flags and Id into internal registers, flip the pointer to the winner, and go to LATCH_A. Requesters may change their inputs after accept.
- Per-state bus outputs (registered decode of state; o_BusValid = 1 on every LATCH_*):
  - LATCH_A: cmd = COM_LATCHA, data = A.
  - LATCH_B: cmd = COM_LATCHB, data = B.
  - LATCH_OP: cmd = COM_LATCHOP, data = {0, Op}. Next state is LATCH_F if LoadF, else COMPUTE.
  - LATCH_F: cmd = COM_LATCHF, data = {0, Flags}.
  - COMPUTE: cmd = COM_COMPUTE, o_BusValid = 0.
  - OUT_Y: cmd = COM_OUTPUTY. At the edge, capture i_BusData into RespY.
  - OUT_F: cmd = COM_OUTPUTF. At the edge, capture i_BusData[FLAGW-1:0] into RespFlags.
- Readback error: in OUT_Y or OUT_F, if i_BusValid = 0 the captured field is 0 and Err is set sticky for this transaction. The sequence continues to RESP regardless.
- RESP: o_RespValid = 1, bus at COM_NOP. Hold every response field stable until i_RespReady. On the edge with Valid & Ready, go to IDLE and clear Err.
- Latency: resp_valid is asserted 7 cycles after the accept edge without LoadF, 8 with LoadF. A back-to-back accept is possible in the cycle after the response handshake.
- The ALU flag contents, including F_ERROR for an undefined opcode, pass through unmodified. The sequencer does not interpret the opcode.
- Reset mid-operation: abort immediately, with bus outputs at COM_NOP asynchronously. An in-flight request is dropped with no response. ALU register contents are then undefined to the client.
- A request withdrawn before accept is legal and has no effect.

Decomposition:
- constants_pkg:
  - COM_* codes;
  - COM_NOP, a code the ALU does not decode;
  - com_t;
  - WORDSIZE;
  - word_t.
- alu_pkg (existing): opcodes and F_* bit indices.
- New typedef in alu_pkg: seq_state_t (enum of the FSM states).
- Sub-module: rr_arbiter2, a 2-way round-robin arbiter with grant, last-grant pointer and update strobe. Reusable for other shared bus slaves.

Test Plan:
- Port 0: ADD, A=0xFFFF, B=0x0001, LoadF=0 -> after 7 cycles RespY=0x0000, RespFlags has F_CARRY and F_ZERO set, RespId=0, Err=0.
- Port 1: ADC, A=0x0002, B=0x0003, LoadF=1, Flags bit F_CARRY=1 -> after 8 cycles RespY=0x0006, F_CARRY=0, RespId=1; bus trace shows LATCHA, LATCHB, LATCHOP, LATCHF, COMPUTE, OUTPUTY, OUTPUTF.
- Both ports valid continuously with distinct ops -> grants alternate 0,1,0,1; no port starves; each response carries the correct Id.
- Hold i_RespReady=0 for 5 cycles -> RespValid and all fields stay stable, both Ready stay 0, bus stays at COM_NOP; accept resumes the cycle after the handshake.
- Force i_BusValid=0 during OUT_Y -> RespY=0 and RespErr=1; the next transaction reports Err=0.
- Assert i_Reset during COMPUTE -> bus goes to COM_NOP in the same cycle, no response is produced, and after release port 0 wins the first tie.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - Argon ALU opcodes, flag bit indices and sequencer states
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_ADC = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;

    localparam int F_CARRY = 0;
    localparam int F_ZERO  = 1;
    localparam int F_NEG   = 2;
    localparam int F_ERROR = 7;

    typedef enum logic [3:0] {
        IDLE,
        LATCH_A,
        LATCH_B,
        LATCH_OP,
        LATCH_F,
        COMPUTE,
        OUT_Y,
        OUT_F,
        RESP
    } seq_state_t;

endpackage

// File: rtl/constants_pkg.sv
// rtl/constants_pkg.sv - Argon bus command codes and word sizing
package constants_pkg;

    localparam int WORDSIZE = 16;

    typedef logic [WORDSIZE-1:0] word_t;

    // COM_NOP sits outside the ALU's decoded command range so an idle bus is inert
    typedef enum logic [2:0] {
        COM_LATCHA  = 3'd0,
        COM_LATCHB  = 3'd1,
        COM_LATCHOP = 3'd2,
        COM_LATCHF  = 3'd3,
        COM_COMPUTE = 3'd4,
        COM_OUTPUTY = 3'd5,
        COM_OUTPUTF = 3'd6,
        COM_NOP     = 3'd7
    } com_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - Two-way round-robin arbiter with last-grant pointer
module rr_arbiter2 (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [1:0] i_Req,
    input  logic       i_Update,
    output logic       o_GrantValid,
    output logic       o_GrantId
);

    logic last_q;

    // On a tie the port that was not granted last wins
    always_comb begin
        o_GrantValid = |i_Req;
        o_GrantId    = (&i_Req) ? ~last_q : i_Req[1];
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            last_q <= 1'b1;
        end else if (i_Update) begin
            last_q <= o_GrantId;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - Two-requester front end driving the Argon ALU bus
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WORDSIZE = 16,
    parameter int FLAGW    = 8
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    input  logic                  i_Req0Valid,
    output logic                  o_Req0Ready,
    input  logic [WORDSIZE-1:0]   i_Req0A,
    input  logic [WORDSIZE-1:0]   i_Req0B,
    input  logic [3:0]            i_Req0Op,
    input  logic                  i_Req0LoadF,
    input  logic [FLAGW-1:0]      i_Req0Flags,
    input  logic                  i_Req1Valid,
    output logic                  o_Req1Ready,
    input  logic [WORDSIZE-1:0]   i_Req1A,
    input  logic [WORDSIZE-1:0]   i_Req1B,
    input  logic [3:0]            i_Req1Op,
    input  logic                  i_Req1LoadF,
    input  logic [FLAGW-1:0]      i_Req1Flags,
    output logic                  o_RespValid,
    input  logic                  i_RespReady,
    output logic                  o_RespId,
    output logic [WORDSIZE-1:0]   o_RespY,
    output logic [FLAGW-1:0]      o_RespFlags,
    output logic                  o_RespErr,
    output constants_pkg::com_t   o_BusCommand,
    output logic [WORDSIZE-1:0]   o_BusData,
    output logic                  o_BusValid,
    input  logic [WORDSIZE-1:0]   i_BusData,
    input  logic                  i_BusValid
);

    seq_state_t          state_q, state_d;
    logic                grant_valid, grant_id;
    logic                accept, resp_fire;
    logic [WORDSIZE-1:0] win_a;
    logic [WORDSIZE-1:0] a_q, b_q;
    logic [3:0]          op_q;
    logic                loadf_q;
    logic [FLAGW-1:0]    flags_q;

    rr_arbiter2 u_arb (
        .i_Clk        (i_Clk),
        .i_Reset      (i_Reset),
        .i_Req        ({i_Req1Valid, i_Req0Valid}),
        .i_Update     (accept),
        .o_GrantValid (grant_valid),
        .o_GrantId    (grant_id)
    );

    always_comb begin
        o_Req0Ready = 1'b0;
        o_Req1Ready = 1'b0;
        if (state_q == IDLE && !i_Reset && grant_valid) begin
            o_Req0Ready = ~grant_id;
            o_Req1Ready = grant_id;
        end
    end

    // Ready is only raised for a valid winner, so any ready is an accept
    assign accept    = o_Req0Ready | o_Req1Ready;
    assign resp_fire = o_RespValid & i_RespReady;
    assign win_a     = grant_id ? i_Req1A : i_Req0A;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept) state_d = LATCH_A;
            LATCH_A:  state_d = LATCH_B;
            LATCH_B:  state_d = LATCH_OP;
            LATCH_OP: state_d = loadf_q ? LATCH_F : COMPUTE;
            LATCH_F:  state_d = COMPUTE;
            COMPUTE:  state_d = OUT_Y;
            OUT_Y:    state_d = OUT_F;
            OUT_F:    state_d = RESP;
            RESP:     if (resp_fire) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            loadf_q  <= 1'b0;
            flags_q  <= '0;
            o_RespId <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q      <= win_a;
                b_q      <= grant_id ? i_Req1B     : i_Req0B;
                op_q     <= grant_id ? i_Req1Op    : i_Req0Op;
                loadf_q  <= grant_id ? i_Req1LoadF : i_Req0LoadF;
                flags_q  <= grant_id ? i_Req1Flags : i_Req0Flags;
                o_RespId <= grant_id;
            end
        end
    end

    // Bus outputs are decoded from the next state so they line up with state_q
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            o_BusCommand <= constants_pkg::COM_NOP;
            o_BusData    <= '0;
            o_BusValid   <= 1'b0;
            o_RespValid  <= 1'b0;
            o_RespY      <= '0;
            o_RespFlags  <= '0;
            o_RespErr    <= 1'b0;
        end else begin
            o_BusCommand <= constants_pkg::COM_NOP;
            o_BusData    <= '0;
            o_BusValid   <= 1'b0;
            o_RespValid  <= (state_d == RESP);
            case (state_d)
                LATCH_A: begin
                    o_BusCommand <= constants_pkg::COM_LATCHA;
                    o_BusData    <= win_a;
                    o_BusValid   <= 1'b1;
                end
                LATCH_B: begin
                    o_BusCommand <= constants_pkg::COM_LATCHB;
                    o_BusData    <= b_q;
                    o_BusValid   <= 1'b1;
                end
                LATCH_OP: begin
                    o_BusCommand <= constants_pkg::COM_LATCHOP;
                    o_BusData    <= WORDSIZE'(op_q);
                    o_BusValid   <= 1'b1;
                end
                LATCH_F: begin
                    o_BusCommand <= constants_pkg::COM_LATCHF;
                    o_BusData    <= WORDSIZE'(flags_q);
                    o_BusValid   <= 1'b1;
                end
                COMPUTE: o_BusCommand <= constants_pkg::COM_COMPUTE;
                OUT_Y:   o_BusCommand <= constants_pkg::COM_OUTPUTY;
                OUT_F:   o_BusCommand <= constants_pkg::COM_OUTPUTF;
                default: ;
            endcase
            if (state_q == OUT_Y) begin
                o_RespY <= i_BusValid ? i_BusData : '0;
                if (!i_BusValid) o_RespErr <= 1'b1;
            end
            if (state_q == OUT_F) begin
                o_RespFlags <= i_BusValid ? i_BusData[FLAGW-1:0] : '0;
                if (!i_BusValid) o_RespErr <= 1'b1;
            end
            if (resp_fire) o_RespErr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - Scoreboard bench for alu_sequencer with a behavioural ALU
module tb_alu_sequencer;
    import constants_pkg::*;
    import alu_pkg::*;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
        logic        loadf;
        logic [7:0]  flags;
    } req_t;

    typedef struct {
        logic        id;
        logic [15:0] y;
        logic [7:0]  f;
        logic        err;
        logic        loadf;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rq_v  [2];
    logic [15:0] rq_a  [2];
    logic [15:0] rq_b  [2];
    logic [3:0]  rq_op [2];
    logic        rq_lf [2];
    logic [7:0]  rq_fl [2];
    logic        rdy0, rdy1;
    logic        resp_valid, resp_ready, resp_id, resp_err;
    logic [15:0] resp_y;
    logic [7:0]  resp_f;
    com_t        bus_cmd;
    logic [15:0] bus_do, bus_di;
    logic        bus_dv, bus_vi;

    int   n_vec = 0, n_mis = 0, cyc = 0, rr_mode = 0;
    req_t pq0[$], pq1[$];
    exp_t sb[$];
    int   grants[$];
    com_t trace[$];
    logic [7:0]  m_flags = '0;
    logic        last_g = 1'b1, bad_y_arm = 1'b0, mon_en = 1'b0;
    logic        resp_seen = 1'b0, b2b_pending = 1'b0;
    logic [25:0] snap;
    logic [15:0] last_y;
    logic [7:0]  last_f;
    logic        last_id, last_err;

    alu_sequencer #(.WORDSIZE(16), .FLAGW(8)) dut (
        .i_Clk(clk), .i_Reset(rst),
        .i_Req0Valid(rq_v[0]), .o_Req0Ready(rdy0), .i_Req0A(rq_a[0]), .i_Req0B(rq_b[0]),
        .i_Req0Op(rq_op[0]), .i_Req0LoadF(rq_lf[0]), .i_Req0Flags(rq_fl[0]),
        .i_Req1Valid(rq_v[1]), .o_Req1Ready(rdy1), .i_Req1A(rq_a[1]), .i_Req1B(rq_b[1]),
        .i_Req1Op(rq_op[1]), .i_Req1LoadF(rq_lf[1]), .i_Req1Flags(rq_fl[1]),
        .o_RespValid(resp_valid), .i_RespReady(resp_ready), .o_RespId(resp_id),
        .o_RespY(resp_y), .o_RespFlags(resp_f), .o_RespErr(resp_err),
        .o_BusCommand(bus_cmd), .o_BusData(bus_do), .o_BusValid(bus_dv),
        .i_BusData(bus_di), .i_BusValid(bus_vi)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Returns {flags, y} for one ALU operation
    function automatic logic [23:0] alu_eval(input logic [15:0] a, input logic [15:0] b,
                                             input logic [3:0] op, input logic [7:0] fin);
        logic [16:0] s;
        logic [7:0]  f;
        s = '0;
        f = '0;
        case (op)
            OP_ADD:  s = {1'b0, a} + {1'b0, b};
            OP_ADC:  s = {1'b0, a} + {1'b0, b} + {16'b0, fin[F_CARRY]};
            OP_SUB:  s = {1'b0, a} - {1'b0, b};
            OP_AND:  s = {1'b0, a & b};
            OP_OR:   s = {1'b0, a | b};
            OP_XOR:  s = {1'b0, a ^ b};
            default: f[F_ERROR] = 1'b1;
        endcase
        f[F_CARRY] = s[16];
        f[F_ZERO]  = (s[15:0] == 16'h0);
        f[F_NEG]   = s[15];
        return {f, s[15:0]};
    endfunction

    // Behavioural Argon ALU on the other side of the bus
    logic [15:0] ra, rb, ry;
    logic [3:0]  rop;
    logic [7:0]  rf;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ra <= '0; rb <= '0; ry <= '0; rop <= '0; rf <= '0;
        end else if (bus_dv) begin
            case (bus_cmd)
                COM_LATCHA:  ra  <= bus_do;
                COM_LATCHB:  rb  <= bus_do;
                COM_LATCHOP: rop <= bus_do[3:0];
                COM_LATCHF:  rf  <= bus_do[7:0];
                default: ;
            endcase
        end else if (bus_cmd == COM_COMPUTE) begin
            {rf, ry} <= alu_eval(ra, rb, rop, rf);
        end
    end

    always_comb begin
        bus_di = 16'h0;
        bus_vi = 1'b0;
        if (bus_cmd == COM_OUTPUTY) begin
            bus_di = ry;
            bus_vi = !bad_y_arm;
        end else if (bus_cmd == COM_OUTPUTF) begin
            bus_di = {8'h0, rf};
            bus_vi = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_req(input int p, input logic [3:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic lf, input logic [7:0] fl);
        req_t r;
        r.a = a; r.b = b; r.op = op; r.loadf = lf; r.flags = fl;
        if (p == 0) pq0.push_back(r);
        else        pq1.push_back(r);
    endtask

    task automatic port_driver(input int p);
        req_t r;
        int   g;
        forever begin
            if ((p == 0 && pq0.size() > 0) || (p == 1 && pq1.size() > 0)) begin
                if (p == 0) r = pq0.pop_front();
                else        r = pq1.pop_front();
                rq_a[p] = r.a; rq_b[p] = r.b; rq_op[p] = r.op;
                rq_lf[p] = r.loadf; rq_fl[p] = r.flags; rq_v[p] = 1'b1;
                g = 0;
                @(negedge clk);
                while (!(p == 0 ? rdy0 : rdy1) && g < 300) begin
                    @(negedge clk);
                    g++;
                end
                if (g >= 300) begin
                    n_vec++; n_mis++;
                    $display("FAIL accept_timeout: port %0d got no ready, expected accept", p);
                end
                @(posedge clk); #1;
            end else begin
                rq_v[p] = 1'b0;
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        resp_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rr_mode)
                0:       resp_ready = 1'b1;
                1:       resp_ready = ($urandom_range(0, 2) != 0);
                default: resp_ready = 1'b0;
            endcase
        end
    end

    // Accept-side model push, response-side pop and compare
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [23:0] r;
        logic [7:0]  fin;
        logic        ew, ok;
        int          p;
        com_t        et[$];
        if (mon_en && !rst) begin
            if (b2b_pending) begin
                b2b_pending = 1'b0;
                if (rq_v[0] || rq_v[1]) chk("b2b_ready", rdy0 | rdy1, 1);
            end
            if (bus_cmd != COM_NOP) trace.push_back(bus_cmd);
            if (rdy0 || rdy1) begin
                chk("ready_onehot", rdy0 & rdy1, 0);
                ew = (rq_v[0] && rq_v[1]) ? !last_g : rq_v[1];
                chk("arb_winner", rdy1, ew);
                p   = rdy1 ? 1 : 0;
                fin = rq_lf[p] ? rq_fl[p] : m_flags;
                r   = alu_eval(rq_a[p], rq_b[p], rq_op[p], fin);
                m_flags = r[23:16];
                e.id = rdy1; e.f = r[23:16]; e.err = bad_y_arm;
                e.y = bad_y_arm ? 16'h0 : r[15:0];
                e.loadf = rq_lf[p];
                e.due = cyc + (rq_lf[p] ? 8 : 7);
                sb.push_back(e);
                last_g = rdy1;
                grants.push_back(p);
            end
            if (resp_valid) begin
                chk("resp_bus_nop", bus_cmd, COM_NOP);
                chk("resp_ready_low", rdy0 | rdy1, 0);
                if (sb.size() == 0) begin
                    n_vec++; n_mis++;
                    $display("FAIL unexpected_response: got id %0d y 0x%0h, expected none", resp_id, resp_y);
                end else begin
                    if (!resp_seen) begin
                        resp_seen = 1'b1;
                        snap = {resp_id, resp_err, resp_f, resp_y};
                        chk("latency", cyc, sb[0].due);
                        et.delete();
                        et.push_back(COM_LATCHA); et.push_back(COM_LATCHB); et.push_back(COM_LATCHOP);
                        if (sb[0].loadf) et.push_back(COM_LATCHF);
                        et.push_back(COM_COMPUTE); et.push_back(COM_OUTPUTY); et.push_back(COM_OUTPUTF);
                        ok = (trace.size() == et.size());
                        for (int i = 0; i < et.size() && ok; i++) if (trace[i] != et[i]) ok = 1'b0;
                        chk("bus_trace", ok, 1);
                    end else begin
                        chk("resp_stable", {6'b0, resp_id, resp_err, resp_f, resp_y}, {6'b0, snap});
                    end
                    if (resp_ready) begin
                        e = sb.pop_front();
                        chk("resp_id", resp_id, e.id);
                        chk("resp_y", resp_y, e.y);
                        chk("resp_flags", resp_f, e.f);
                        chk("resp_err", resp_err, e.err);
                        last_y = resp_y; last_f = resp_f; last_id = resp_id; last_err = resp_err;
                        resp_seen = 1'b0;
                        b2b_pending = 1'b1;
                        trace.delete();
                    end
                end
            end
        end
    end

    task automatic wait_idle(input string tag);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!(pq0.size() == 0 && pq1.size() == 0 && !rq_v[0] && !rq_v[1] &&
                     sb.size() == 0 && !resp_valid) && g < 3000);
        if (g >= 3000) begin
            n_vec++; n_mis++;
            $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", tag, g);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis + 1);
        $fatal(1);
    end

    initial begin
        int g0, g;
        logic seen;
        for (int i = 0; i < 2; i++) begin
            rq_v[i] = 1'b1; rq_a[i] = 16'h1234; rq_b[i] = 16'h5678;
            rq_op[i] = OP_ADD; rq_lf[i] = 1'b0; rq_fl[i] = 8'h0;
        end
        repeat (3) @(negedge clk);
        chk("rst_ready0", rdy0, 0);
        chk("rst_ready1", rdy1, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_fields", {resp_id, resp_err, resp_f, resp_y}, 0);
        chk("rst_bus_cmd", bus_cmd, COM_NOP);
        chk("rst_bus_data", {bus_dv, bus_do}, 0);
        rq_v[0] = 1'b0; rq_v[1] = 1'b0;
        mon_en = 1'b1;
        rst = 1'b0;
        fork
            port_driver(0);
            port_driver(1);
        join_none

        push_req(0, OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 8'h00);
        wait_idle("add");
        chk("add_y", last_y, 16'h0000);
        chk("add_carry", last_f[F_CARRY], 1);
        chk("add_zero", last_f[F_ZERO], 1);
        chk("add_id", last_id, 0);
        chk("add_err", last_err, 0);

        push_req(1, OP_ADC, 16'h0002, 16'h0003, 1'b1, 8'h01);
        wait_idle("adc");
        chk("adc_y", last_y, 16'h0006);
        chk("adc_carry", last_f[F_CARRY], 0);
        chk("adc_id", last_id, 1);

        @(negedge clk);
        g0 = grants.size();
        for (int k = 0; k < 4; k++) begin
            push_req(0, 4'(k), 16'h1000 + 16'(k), 16'h0F0F, 1'b0, 8'h00);
            push_req(1, 4'(k + 2), 16'h2000 + 16'(k), 16'h00FF, k[0], 8'h01);
        end
        wait_idle("rr");
        chk("rr_count", grants.size() - g0, 8);
        for (int k = 0; k < 8 && g0 + k < grants.size(); k++) chk("rr_alternate", grants[g0 + k], k % 2);

        rr_mode = 2;
        push_req(0, OP_XOR, 16'hA5A5, 16'h5A5A, 1'b0, 8'h00);
        push_req(1, OP_SUB, 16'h0001, 16'h0002, 1'b0, 8'h00);
        g = 0;
        while (!resp_valid && g < 50) begin @(negedge clk); g++; end
        chk("stall_resp_arrives", resp_valid, 1);
        repeat (5) @(negedge clk);
        rr_mode = 0;
        wait_idle("stall");

        bad_y_arm = 1'b1;
        push_req(0, OP_OR, 16'h00F0, 16'h0F00, 1'b0, 8'h00);
        wait_idle("bad_y");
        bad_y_arm = 1'b0;
        chk("bad_y_zero", last_y, 16'h0000);
        chk("bad_y_err", last_err, 1);
        push_req(0, OP_AND, 16'h00FF, 16'h0F0F, 1'b0, 8'h00);
        wait_idle("after_bad");
        chk("err_cleared", last_err, 0);
        chk("after_bad_y", last_y, 16'h000F);

        push_req(0, OP_ADD, 16'h1111, 16'h2222, 1'b0, 8'h00);
        g = 0;
        do begin @(negedge clk); g++; end while (bus_cmd != COM_COMPUTE && g < 50);
        rst = 1'b1;
        #1;
        chk("abort_bus_nop", bus_cmd, COM_NOP);
        chk("abort_bus_valid", bus_dv, 0);
        sb.delete(); trace.delete();
        m_flags = '0; last_g = 1'b1; resp_seen = 1'b0; b2b_pending = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin @(negedge clk); seen = seen | resp_valid; end
        chk("no_resp_after_abort", seen, 0);
        g0 = grants.size();
        push_req(1, OP_SUB, 16'h0005, 16'h0003, 1'b0, 8'h00);
        push_req(0, OP_ADD, 16'h0005, 16'h0003, 1'b0, 8'h00);
        wait_idle("post_reset");
        if (grants.size() > g0) chk("post_reset_port0_first", grants[g0], 0);
        else chk("post_reset_grants", grants.size() - g0, 2);

        rr_mode = 1;
        for (int k = 0; k < 40; k++) begin
            push_req($urandom_range(0, 1), 4'($urandom_range(0, 7)), 16'($urandom),
                     16'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 12)) @(negedge clk);
        end
        wait_idle("random");
        rr_mode = 0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
